// File: rtl/picture_pkg.sv
// Shared types and helpers for the double-buffered picture memory.
package picture_pkg;

  localparam int CH_W_DEF  = 6;
  localparam int PIX_W_DEF = 3 * CH_W_DEF;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  typedef enum logic {
    LOAD      = 1'b0,
    WAIT_SWAP = 1'b1
  } load_state_t;

  function automatic int pix_count(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/rgb_byte_assembler.sv
// Collects R,G,B bytes into one pixel; strobes combinationally on the B byte.
module rgb_byte_assembler
  import picture_pkg::*;
#(
  parameter int CH_W = CH_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  output logic [3*CH_W-1:0] o_pixel,
  output logic              o_strobe
);

  logic [1:0]      r_phase;
  logic [CH_W-1:0] r_r;
  logic [CH_W-1:0] r_g;
  logic [1:0]      w_phase;
  logic [CH_W-1:0] w_chan;
  logic            w_take;
  logic            w_unused_ok;

  // A clear in the same cycle as a byte makes that byte the R channel.
  always_comb begin
    w_phase = i_clear ? 2'd0 : r_phase;
    w_chan  = i_byte[7 -: CH_W];
    w_take  = i_enable && i_valid;
  end

  assign o_strobe    = w_take && (w_phase == 2'd2);
  assign o_pixel     = {r_r, r_g, w_chan};
  assign w_unused_ok = &{1'b0, i_byte};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= 2'd0;
      r_r     <= '0;
      r_g     <= '0;
    end else if (w_take) begin
      case (w_phase)
        2'd0: begin
          r_r     <= w_chan;
          r_phase <= 2'd1;
        end
        2'd1: begin
          r_g     <= w_chan;
          r_phase <= 2'd2;
        end
        default: r_phase <= 2'd0;
      endcase
    end else begin
      r_phase <= w_phase;
    end
  end

endmodule

// File: rtl/picture_buffer_dual.sv
// Double-buffered picture memory: UART bytes fill the back bank, VGA raster reads the front.
// Optional colour-bar display before the first frame: define PICTURE_TEST_PATTERN_EN.
module picture_buffer_dual
  import picture_pkg::*;
#(
  parameter int H_SIZE = 320,
  parameter int V_SIZE = 240,
  parameter int CH_W   = CH_W_DEF,
  parameter int PIX_W  = 3 * CH_W,
  parameter int ADDR_W = $clog2(2 * H_SIZE * V_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             frame_start,
  input  logic [10:0]      h_count,
  input  logic [9:0]       v_count,
  output logic             synch_pulse,
  output logic [PIX_W-1:0] raw_rgb,
  output logic             pix_valid,
  output logic             loaded,
  output logic             active_bank,
  output logic             overflow_err,
  output load_state_t      o_dbg_state
);

  localparam int N = pix_count(H_SIZE, V_SIZE);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(N);
  localparam logic [10:0]       H_LIM      = 11'(H_SIZE);
  localparam logic [9:0]        V_LIM      = 10'(V_SIZE);

  load_state_t       r_state;
  load_state_t       w_state_nxt;
  logic              r_active_bank;
  logic              r_loaded;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_wr_idx;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [PIX_W-1:0]  r_ram [0:2*N-1];
  logic [PIX_W-1:0]  r_ram_q;
  logic              r_s1_valid;
  logic              r_s1_sync;
  logic [PIX_W-1:0]  w_pixel;
  logic [PIX_W-1:0]  w_s1_pixel;
  logic              w_strobe;
  logic              w_origin;
  logic              w_in_image;
  logic              w_swap;
  logic              w_wr_en;
  logic              w_overflow_set;
  logic              w_restart;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [ADDR_W-1:0] w_rd_addr;

  // rx_valid is a one-cycle strobe with no backpressure: any byte not taken in LOAD is lost.
  assign w_origin   = (h_count == 11'd0) && (v_count == 10'd0);
  assign w_in_image = (h_count < H_LIM) && (v_count < V_LIM);
  assign w_restart  = frame_start && (r_state == LOAD);

  rgb_byte_assembler #(.CH_W(CH_W)) u_asm (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (w_restart || w_swap),
    .i_enable (r_state == LOAD),
    .i_valid  (rx_valid),
    .i_byte   (rx_byte),
    .o_pixel  (w_pixel),
    .o_strobe (w_strobe)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en        = 1'b0;
    w_swap         = 1'b0;
    w_overflow_set = 1'b0;
    case (r_state)
      LOAD: begin
        w_wr_en = w_strobe;
        if (w_strobe && (r_wr_idx == LAST_IDX)) w_state_nxt = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        w_overflow_set = rx_valid;
        if (w_origin) begin
          w_swap      = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Back bank is always the one not displayed; the swap cycle already reads the new front.
  assign w_wr_addr = r_active_bank ? r_wr_idx : BANK1_BASE + r_wr_idx;
  assign w_rd_idx  = w_origin ? '0 : r_rd_idx;
  assign w_rd_addr = (r_active_bank ^ w_swap) ? BANK1_BASE + w_rd_idx : w_rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LOAD;
      r_active_bank <= 1'b0;
      r_loaded      <= 1'b0;
      r_overflow    <= 1'b0;
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap) begin
        r_active_bank <= ~r_active_bank;
        r_loaded      <= 1'b1;
      end
      if (w_overflow_set) r_overflow <= 1'b1;
      if (w_swap || w_restart) r_wr_idx <= '0;
      else if (w_wr_en)        r_wr_idx <= r_wr_idx + 1'b1;
      r_rd_idx <= w_in_image ? w_rd_idx + 1'b1 : w_rd_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_ram[w_wr_addr] <= w_pixel;
    r_ram_q <= r_ram[w_rd_addr];
  end

`ifdef PICTURE_TEST_PATTERN_EN
  logic [2:0]       w_bar;
  logic             r_s1_pat;
  logic [PIX_W-1:0] r_s1_bars;

  assign w_bar = 3'((32'(h_count) * 32'd8) / 32'(H_SIZE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_pat  <= 1'b0;
      r_s1_bars <= '0;
    end else begin
      r_s1_pat  <= !(r_loaded || w_swap);
      r_s1_bars <= {{CH_W{w_bar[2]}}, {CH_W{w_bar[1]}}, {CH_W{w_bar[0]}}};
    end
  end

  assign w_s1_pixel = r_s1_pat ? r_s1_bars : r_ram_q;
`else
  assign w_s1_pixel = r_ram_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sync   <= 1'b0;
      raw_rgb     <= '0;
      pix_valid   <= 1'b0;
      synch_pulse <= 1'b0;
    end else begin
      r_s1_valid  <= w_in_image;
      r_s1_sync   <= (h_count == 11'd0) && (v_count < V_LIM);
      raw_rgb     <= r_s1_valid ? w_s1_pixel : '0;
      pix_valid   <= r_s1_valid;
      synch_pulse <= r_s1_sync;
    end
  end

  assign loaded       = r_loaded;
  assign active_bank  = r_active_bank;
  assign overflow_err = r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_picture_buffer_dual.sv
// Bench for picture_buffer_dual on a 4x2 image inside an 8x4 free-running raster.
module tb_picture_buffer_dual;
  import picture_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;
  localparam int PW = 18;
  localparam int HT = 8;
  localparam int VT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_byte = 8'd0;
  logic          rx_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [10:0]   h_count = 11'd0;
  logic [9:0]    v_count = 10'd0;
  logic          synch_pulse;
  logic [PW-1:0] raw_rgb;
  logic          pix_valid;
  logic          loaded;
  logic          active_bank;
  logic          overflow_err;
  load_state_t   dbg_state;

  always #5 clk = ~clk;

  picture_buffer_dual #(.H_SIZE(H), .V_SIZE(V), .CH_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .frame_start  (frame_start),
    .h_count      (h_count),
    .v_count      (v_count),
    .synch_pulse  (synch_pulse),
    .raw_rgb      (raw_rgb),
    .pix_valid    (pix_valid),
    .loaded       (loaded),
    .active_bank  (active_bank),
    .overflow_err (overflow_err),
    .o_dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference: bytes of the frame being loaded, last completed frame, displayed frame.
  logic [7:0] m_bytes[$];
  rgb_t       m_done[N];
  rgb_t       m_front[N];
  bit         m_wait, m_loaded, m_active, m_ovf;

  // Expected outputs: one stage in flight, one stage at the outputs.
  logic [PW-1:0] s1_rgb, ex_rgb;
  bit            s1_valid, s1_sync, s1_care, ex_valid, ex_sync, ex_care;
  int            hc = 0;
  int            vc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d t=%0t)", tag, obs, exp, hc, vc, $time);
    end
  endtask

  function automatic logic [PW-1:0] bar_colour(input int h);
    int bar;
    bar = (h * 8) / H;
    return {(bar & 4) != 0 ? 6'h3F : 6'h00, (bar & 2) != 0 ? 6'h3F : 6'h00,
            (bar & 1) != 0 ? 6'h3F : 6'h00};
  endfunction

  task automatic model_edge(input bit rv, input logic [7:0] b, input bit fs, input bit rst);
    logic [7:0] br, bg, bb;
    bit in_img;
    if (rst) begin
      m_bytes.delete();
      m_wait = 0; m_loaded = 0; m_active = 0; m_ovf = 0;
      s1_rgb = '0; s1_valid = 0; s1_sync = 0; s1_care = 1;
      ex_rgb = '0; ex_valid = 0; ex_sync = 0; ex_care = 1;
      return;
    end
    ex_rgb = s1_rgb; ex_valid = s1_valid; ex_sync = s1_sync; ex_care = s1_care;
    if (m_wait) begin
      if (rv) m_ovf = 1;
      if (hc == 0 && vc == 0) begin
        m_wait = 0; m_loaded = 1; m_active = ~m_active;
        m_front = m_done;
        m_bytes.delete();
      end
    end else begin
      if (fs) m_bytes.delete();
      if (rv) begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 3 * N) begin
          for (int k = 0; k < N; k++) begin
            br = m_bytes[3*k]; bg = m_bytes[3*k+1]; bb = m_bytes[3*k+2];
            m_done[k] = '{r: br[7:2], g: bg[7:2], b: bb[7:2]};
          end
          m_bytes.delete();
          m_wait = 1;
        end
      end
    end
    in_img   = (hc < H) && (vc < V);
    s1_valid = in_img;
    s1_sync  = (hc == 0) && (vc < V);
    s1_care  = 1;
    s1_rgb   = '0;
    if (in_img) begin
`ifdef PICTURE_TEST_PATTERN_EN
      if (!m_loaded) s1_rgb = bar_colour(hc);
      else           s1_rgb = m_front[vc*H + hc];
`else
      s1_care = m_loaded;
      if (m_loaded) s1_rgb = m_front[vc*H + hc];
`endif
    end
  endtask

  task automatic check_outputs();
    chk("pix_valid", 32'(pix_valid), 32'(ex_valid));
    chk("synch_pulse", 32'(synch_pulse), 32'(ex_sync));
    if (ex_care) chk("raw_rgb", 32'(raw_rgb), 32'(ex_rgb));
    chk("loaded", 32'(loaded), 32'(m_loaded));
    chk("active_bank", 32'(active_bank), 32'(m_active));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("state", 32'(dbg_state), m_wait ? 32'(WAIT_SWAP) : 32'(LOAD));
  endtask

  task automatic cycle(input bit rv, input logic [7:0] b, input bit fs, input bit rst);
    rx_valid = rv; rx_byte = b; frame_start = fs; reset = rst;
    h_count = 11'(hc); v_count = 10'(vc);
    @(posedge clk);
    model_edge(rv, b, fs, rst);
    #1;
    check_outputs();
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc + 1) % VT;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'd0, 0, 0);
  endtask

  // Runs through the next origin cycle so following bytes start right after it.
  task automatic pass_origin();
    while (!(hc == 0 && vc == 0)) cycle(0, 8'd0, 0, 0);
    cycle(0, 8'd0, 0, 0);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1, b, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle(0, 8'd0, 0, 1);
    idle(40);

    // Known frame: pixel k = (4k, 4k+1, 4k+2) gives {k,k,k}.
    pass_origin();
    for (int k = 0; k < N; k++)
      for (int c = 0; c < 3; c++) send(8'(4*k + c));
    pass_origin();
    chk("t1_active_after_swap", 32'(active_bank), 32'd1);
    chk("t1_pixel1", 32'(m_front[1]), 32'({6'd1, 6'd1, 6'd1}));
    idle(40);

    // Full frame plus three bytes dropped while waiting for the origin.
    pass_origin();
    for (int i = 0; i < 3 * N + 3; i++) send(8'($urandom_range(0, 255)));
    idle(2);
    chk("t2_overflow", 32'(overflow_err), 32'd1);
    idle(70);

    // Restart after 5 bytes; restart cycle carries the R byte of pixel 0.
    pass_origin();
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
    cycle(1, 8'hC4, 1, 0);
    for (int i = 0; i < 3 * N - 1; i++) send(8'($urandom_range(0, 255)));
    idle(70);

    // Reset in the middle of a load, then a full load swaps into bank 1 again.
    pass_origin();
    for (int i = 0; i < 12; i++) send(8'($urandom_range(0, 255)));
    cycle(0, 8'd0, 0, 1);
    chk("t5_loaded_cleared", 32'(loaded), 32'd0);
    idle(40);
    pass_origin();
    for (int i = 0; i < 3 * N; i++) send(8'($urandom_range(0, 255)));
    pass_origin();
    chk("t5_active_after_reload", 32'(active_bank), 32'd1);
    idle(40);

    // Random traffic with occasional restarts and sporadic resets.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
            $urandom_range(0, 59) == 0, $urandom_range(0, 499) == 0);
    end
    idle(70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
